// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: NOP encoding, fetch FSM states
// and the default reset PC.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load-enable, bubble insertion, synchronous active-low reset.
// A bubble clears the instruction and valid bit but keeps the last PC+4.
module ifid_reg
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              bubble,
    input  logic [31:0]       instr,
    input  logic [ADDR_W-1:0] pc_plus4,
    output logic [31:0]       instr_q,
    output logic [ADDR_W-1:0] pc_plus4_q,
    output logic              valid_q
);

    // NOTE: reset is sampled on the clock edge (synchronous), and all state
    // is updated with non-blocking assignments so registers read old values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (load_en) begin
            if (bubble) begin
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
            end else begin
                instr_q    <= instr;
                pc_plus4_q <= pc_plus4;
                valid_q    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch controller: PC register, instruction-memory handshake, stall/redirect
// handling and the IF/ID register. Optional macro DELAY_SLOT_EN keeps the redirect-cycle word.
module if_fetch_ctrl
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PCEn,
    input  logic              IF_ID_En,
    input  logic              Branch_Taken,
    input  logic [ADDR_W-1:0] Branch_Target,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] Jump_Target,
    output logic              IMem_Req,
    output logic [ADDR_W-1:0] IMem_Addr,
    input  logic              IMem_Ready,
    input  logic [31:0]       IMem_Rdata,
    output logic [31:0]       Instr_ID,
    output logic [ADDR_W-1:0] PC_plus4_ID,
    output logic              Valid_ID,
    output logic              Fetch_Stall
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic              pending;
    logic              pending_d;
    logic [ADDR_W-1:0] pending_target;
    logic [ADDR_W-1:0] pending_target_d;
    logic              redirect;
    logic [ADDR_W-1:0] redir_target;
    logic              data_valid;
    logic              ifid_bubble;

    // Redirects only count while the PC may move; stalled ID operands are stale.
    assign redirect     = PCEn && (Branch_Taken || Jump);
    assign redir_target = (Branch_Taken ? Branch_Target : Jump_Target) & ALIGN_MASK;
    assign pc_plus4     = pc_q + ADDR_W'(4);
    assign data_valid   = (state != ST_HOLD) && IMem_Ready;
    assign IMem_Addr    = pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_HOLD;
            IMem_Req    <= 1'b0;
            Fetch_Stall <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    state       <= ST_FETCH;
                    IMem_Req    <= 1'b1;
                    Fetch_Stall <= 1'b0;
                end
                ST_FETCH, ST_WAIT: begin
                    IMem_Req <= 1'b1;
                    if (IMem_Ready) begin
                        state       <= ST_FETCH;
                        Fetch_Stall <= 1'b0;
                    end else begin
                        state       <= ST_WAIT;
                        Fetch_Stall <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_HOLD;
                    IMem_Req    <= 1'b0;
                    Fetch_Stall <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        pc_d             = pc_q;
        pending_d        = pending;
        pending_target_d = pending_target;
        if (data_valid) begin
            if (pending) begin
                // Word arriving after a latched redirect is on the wrong path.
                pc_d      = redirect ? redir_target : pending_target;
                pending_d = 1'b0;
            end else if (redirect) begin
                pc_d = redir_target;
            end else if (PCEn) begin
                pc_d = pc_plus4;
            end
        end else if (redirect) begin
            pending_d        = 1'b1;
            pending_target_d = redir_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q           <= PC_RESET & ALIGN_MASK;
            pending        <= 1'b0;
            pending_target <= '0;
        end else begin
            pc_q           <= pc_d;
            pending        <= pending_d;
            pending_target <= pending_target_d;
        end
    end

    // A real word enters IF/ID only when it arrived, is on the right path and
    // the PC advances past it (a held PC refetches the same word).
    always_comb begin
        ifid_bubble = 1'b1;
        if (data_valid && !pending && PCEn) begin
`ifdef DELAY_SLOT_EN
            ifid_bubble = 1'b0;
`else
            ifid_bubble = redirect;
`endif
        end
    end

    ifid_reg #(
        .ADDR_W (ADDR_W)
    ) u_ifid_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (IF_ID_En),
        .bubble     (ifid_bubble),
        .instr      (IMem_Rdata),
        .pc_plus4   (pc_plus4),
        .instr_q    (Instr_ID),
        .pc_plus4_q (PC_plus4_ID),
        .valid_q    (Valid_ID)
    );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a behavioural model.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCEn, IF_ID_En, Branch_Taken, Jump, IMem_Ready;
    logic [31:0] Branch_Target, Jump_Target, IMem_Rdata;
    logic        IMem_Req, Valid_ID, Fetch_Stall;
    logic [31:0] IMem_Addr, Instr_ID, PC_plus4_ID;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Behavioural model of the visible fetch behaviour.
    bit          m_req, m_stall, m_valid;
    logic [31:0] m_pc, m_instr, m_pc4;
    logic [31:0] pend_q[$];

    if_fetch_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PCEn          (PCEn),
        .IF_ID_En      (IF_ID_En),
        .Branch_Taken  (Branch_Taken),
        .Branch_Target (Branch_Target),
        .Jump          (Jump),
        .Jump_Target   (Jump_Target),
        .IMem_Req      (IMem_Req),
        .IMem_Addr     (IMem_Addr),
        .IMem_Ready    (IMem_Ready),
        .IMem_Rdata    (IMem_Rdata),
        .Instr_ID      (Instr_ID),
        .PC_plus4_ID   (PC_plus4_ID),
        .Valid_ID      (Valid_ID),
        .Fetch_Stall   (Fetch_Stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit          got, redir, keep;
        logic [31:0] tgt, nxt_pc;
        if (!rst_n) begin
            m_req = 0; m_stall = 0; m_valid = 0;
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
            pend_q.delete();
            return;
        end
        got    = m_req && IMem_Ready;
        redir  = PCEn && (Branch_Taken || Jump);
        tgt    = (Branch_Taken ? Branch_Target : Jump_Target) & 32'hFFFF_FFFC;
        nxt_pc = m_pc;
`ifdef DELAY_SLOT_EN
        keep = got && pend_q.size() == 0 && PCEn;
`else
        keep = got && pend_q.size() == 0 && PCEn && !redir;
`endif
        if (IF_ID_En) begin
            if (keep) begin
                m_instr = IMem_Rdata;
                m_pc4   = m_pc + 32'd4;
                m_valid = 1;
            end else begin
                m_instr = 32'h0;
                m_valid = 0;
            end
        end
        if (got) begin
            if (pend_q.size() != 0) begin
                nxt_pc = redir ? tgt : pend_q[0];
                pend_q.delete();
            end else if (redir) begin
                nxt_pc = tgt;
            end else if (PCEn) begin
                nxt_pc = m_pc + 32'd4;
            end
        end else if (redir) begin
            pend_q.delete();
            pend_q.push_back(tgt);
        end
        m_pc    = nxt_pc;
        m_stall = m_req && !IMem_Ready;
        m_req   = 1;
    endtask

    // Single compare process: outputs are registered, so mid-cycle sampling is stable.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("IMem_Req",    {31'b0, IMem_Req},    {31'b0, m_req});
            check("Fetch_Stall", {31'b0, Fetch_Stall}, {31'b0, m_stall});
            check("IMem_Addr",   IMem_Addr,            m_pc);
            check("Instr_ID",    Instr_ID,             m_instr);
            check("PC_plus4_ID", PC_plus4_ID,          m_pc4);
            check("Valid_ID",    {31'b0, Valid_ID},    {31'b0, m_valid});
        end
    end

    task automatic step(input bit r, input bit p, input bit e,
                        input bit b, input logic [31:0] bt,
                        input bit j, input logic [31:0] jt,
                        input bit rdy, input bit auto_rd, input logic [31:0] rd);
        @(negedge clk);
        rst_n = r; PCEn = p; IF_ID_En = e;
        Branch_Taken = b; Branch_Target = bt;
        Jump = j; Jump_Target = jt;
        IMem_Ready = rdy;
        IMem_Rdata = auto_rd ? (32'h1000_0000 + IMem_Addr) : rd;
        @(posedge clk);
        model_step();
    endtask

    task automatic run(input bit rdy);
        step(1, 1, 1, 0, 0, 0, 0, rdy, 1, 0);
    endtask

    initial begin
        rst_n = 0; PCEn = 0; IF_ID_En = 0; Branch_Taken = 0; Jump = 0;
        Branch_Target = 0; Jump_Target = 0; IMem_Ready = 0; IMem_Rdata = 0;

        step(0, 1, 1, 0, 0, 0, 0, 1, 1, 0);
        cmp_en = 1'b1;
        step(0, 1, 1, 0, 0, 0, 0, 1, 1, 0);
        #1;
        check("reset_req",   {31'b0, IMem_Req},    32'h0);
        check("reset_addr",  IMem_Addr,            32'h0);
        check("reset_instr", Instr_ID,             32'h0);
        check("reset_valid", {31'b0, Valid_ID},    32'h0);
        check("reset_stall", {31'b0, Fetch_Stall}, 32'h0);

        // Straight-line fetch with zero-wait memory.
        run(1); #1;
        check("hold_then_req", {31'b0, IMem_Req}, 32'h1);
        check("first_addr",    IMem_Addr,         32'h0);
        run(1); #1;
        check("addr_4",        IMem_Addr,         32'h4);
        check("instr_0",       Instr_ID,          32'h1000_0000);
        check("pc4_0",         PC_plus4_ID,       32'h4);
        run(1); #1;
        check("addr_8",        IMem_Addr,         32'h8);
        run(1); #1;
        check("addr_c",        IMem_Addr,         32'hC);
        check("instr_8",       Instr_ID,          32'h1000_0008);
        run(1);

        // Three wait states at 0x10.
        run(0); #1;
        check("stall_on",    {31'b0, Fetch_Stall}, 32'h1);
        check("addr_held",   IMem_Addr,            32'h10);
        check("wait_bubble", {31'b0, Valid_ID},    32'h0);
        run(0);
        run(0);
        run(1); #1;
        check("wait_data",   Instr_ID,             32'h1000_0010);
        check("wait_pc",     IMem_Addr,            32'h14);
        check("stall_off",   {31'b0, Fetch_Stall}, 32'h0);

        // Two-cycle stall at 0x20.
        repeat (3) run(1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0); #1;
        check("stall_pc",    IMem_Addr, 32'h20);
        check("stall_instr", Instr_ID,  32'h1000_001C);
        run(1); #1;
        check("refetch",     Instr_ID,  32'h1000_0020);

        // Branch at 0x40, branch-over-jump priority, ignored branch under stall.
        repeat (7) run(1);
        step(1, 1, 1, 1, 32'h100, 0, 0, 1, 1, 0); #1;
        check("br_addr",  IMem_Addr, 32'h100);
`ifdef DELAY_SLOT_EN
        check("br_slot",  Instr_ID,  32'h1000_0040);
        check("br_valid", {31'b0, Valid_ID}, 32'h1);
`else
        check("br_squash", Instr_ID, 32'h0);
        check("br_valid",  {31'b0, Valid_ID}, 32'h0);
`endif
        step(1, 1, 1, 1, 32'h300, 1, 32'h200, 1, 1, 0); #1;
        check("br_prio",     IMem_Addr, 32'h300);
        step(1, 0, 0, 1, 32'h500, 0, 0, 1, 1, 0); #1;
        check("br_ignored",  IMem_Addr, 32'h300);
        run(1); #1;
        check("after_ign",   IMem_Addr, 32'h304);

        // Jump while waiting: returned word dropped.
        run(0);
        step(1, 1, 1, 0, 0, 1, 32'h200, 0, 1, 0);
        run(1); #1;
        check("jmp_wait_addr",  IMem_Addr,         32'h200);
        check("jmp_wait_valid", {31'b0, Valid_ID}, 32'h0);

        // Reset during WAIT; late ready ignored.
        run(0);
        step(0, 1, 1, 0, 0, 0, 0, 1, 1, 0); #1;
        check("rst_wait_req",   {31'b0, IMem_Req},    32'h0);
        check("rst_wait_stall", {31'b0, Fetch_Stall}, 32'h0);
        run(1); #1;
        check("rst_hold_addr",  IMem_Addr,         32'h0);
        check("rst_hold_valid", {31'b0, Valid_ID}, 32'h0);

        // PC wrap and target alignment.
        step(1, 1, 1, 0, 0, 1, 32'hFFFF_FFFE, 1, 1, 0); #1;
        check("align_addr", IMem_Addr, 32'hFFFF_FFFC);
        run(1); #1;
        check("wrap_addr",  IMem_Addr,   32'h0);
        check("wrap_pc4",   PC_plus4_ID, 32'h0);
        check("wrap_instr", Instr_ID,    32'h0FFF_FFFC);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bit p;
            p = ($urandom_range(3) != 0);
            step($urandom_range(63) != 0, p,
                 ($urandom_range(7) == 0) ? bit'($urandom_range(1)) : p,
                 $urandom_range(7) == 0, $urandom,
                 $urandom_range(7) == 0, $urandom,
                 $urandom_range(2) != 0, 0, $urandom);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Fetch-side consumer of the pipeline stall/flush controls.
- Holds the PC register and drives the instruction-memory request with a ready handshake.
- Applies the PCEn / IF_ID_En stall enables and branch/jump redirects.
- Owns the IF/ID pipeline register that feeds the ID stage and the hazard logic.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC and instruction-memory address width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, active-low, synchronous
- PCEn  input  1  PC update enable from hazard unit (0 = stall)
- IF_ID_En  input  1  IF/ID register load enable from hazard unit
- Branch_Taken  input  1  branch resolved taken in ID
- Branch_Target  input  ADDR_W  branch target address
- Jump  input  1  jump decoded in ID
- Jump_Target  input  ADDR_W  jump target address
- IMem_Req  output  1  instruction fetch request
- IMem_Addr  output  ADDR_W  fetch address
- IMem_Ready  input  1  instruction memory returns data this cycle
- IMem_Rdata  input  32  instruction word
- Instr_ID  output  32  IF/ID instruction
- PC_plus4_ID  output  ADDR_W  IF/ID PC+4
- Valid_ID  output  1  IF/ID holds a real instruction
- Fetch_Stall  output  1  fetch waiting on memory

Behaviour:
- Reset:
  - Single clock; reset is synchronous and active-low (rst_n sampled on rising clk).
  - On reset: PC=PC_RESET, state=HOLD, IMem_Req=0, Instr_ID=32'h0 (NOP), PC_plus4_ID=0, Valid_ID=0, Fetch_Stall=0, pending redirect cleared.
  - Reset asserted mid-fetch abandons the request; late IMem_Ready is ignored while in HOLD.
- FSM states: HOLD, FETCH, WAIT.
- HOLD:
  - IMem_Req=0.
  - Next cycle goes to FETCH (one bubble after reset release).
- FETCH:
  - IMem_Req=1, IMem_Addr=PC.
  - IMem_Ready=1: data valid this cycle (zero-wait memory).
  - IMem_Ready=0: go to WAIT, Fetch_Stall=1 from the next cycle.
- WAIT:
  - IMem_Req=1; IMem_Addr held at PC (unchanged).
  - Fetch_Stall=1 until the cycle IMem_Ready=1, then back to FETCH.
- Redirect source select:
  - Branch_Taken has priority over Jump.
  - Target = Branch_Target if Branch_Taken, else Jump_Target.
  - Redirect is honoured only when PCEn=1; with PCEn=0 the ID operands are stale, so redirect inputs are ignored.
- Update in a data-valid cycle (FETCH or WAIT with IMem_Ready=1):
  - PCEn=1, no redirect: PC <= PC+4.
  - PCEn=1, redirect: PC <= target.
  - PCEn=0: PC held and the fetched word is discarded; the same address is refetched next cycle.
  - IF_ID_En=1, no redirect: Instr_ID <= IMem_Rdata, PC_plus4_ID <= PC+4, Valid_ID <= 1.
  - IF_ID_En=1, redirect: IF/ID loads a bubble (Instr_ID=0, Valid_ID=0), since the fetched word is on the wrong path.
  - IF_ID_En=0: IF/ID held.
- No data this cycle (WAIT with IMem_Ready=0, or HOLD):
  - IF_ID_En=1 loads a bubble into IF/ID.
  - A redirect seen with PCEn=1 is latched in pending_redirect with its target.
  - When data then arrives, it is dropped, PC <= latched target, IF/ID gets a bubble, and pending is cleared.
  - A second redirect while pending overwrites the latched target.
- Arithmetic: PC+4 computed modulo 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0. PC[1:0] forced to 0 on every load.
- Latency: instruction presented on IMem_Rdata in cycle N appears on Instr_ID in cycle N+1.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- Defined (MIPS branch delay slot): on a redirect, the word fetched in the same cycle is kept; it loads into IF/ID normally with Valid_ID=1. A pending redirect still discards data arriving after it.
- Undefined: the redirect-cycle word is squashed to a bubble, as above.

Decomposition:
- Shared package mips_pkg:
  - NOP_INSTR = 32'h0000_0000
  - fetch state encoding (HOLD/FETCH/WAIT)
  - default PC_RESET constant
- One natural sub-module: ifid_reg, the IF/ID pipeline register, with load-enable, bubble-insert input and synchronous active-low reset.

Test Plan:
- Reset release, IMem_Ready tied 1, PCEn=IF_ID_En=1 -> IMem_Addr sequence 0,4,8,C from cycle 2; Instr_ID follows rdata one cycle later; Valid_ID=1.
- IMem_Ready low 3 cycles at addr 0x10 -> Fetch_Stall=1 for 3 cycles, IMem_Addr held 0x10; IF/ID gets bubbles; data on 4th cycle lands in Instr_ID; PC goes to 0x14.
- PCEn=IF_ID_En=0 for 2 cycles at PC 0x20 -> PC and Instr_ID unchanged; 0x20 is refetched after release.
- Branch_Taken=1, Branch_Target=0x100 at PC 0x40, PCEn=1 -> next IMem_Addr=0x100. Macro off: Instr_ID=0, Valid_ID=0. Macro on: word at 0x40 loads with Valid_ID=1.
- Jump to 0x200 while in WAIT -> returned word dropped, next IMem_Addr=0x200.
- Branch_Taken and Jump both 1 -> Branch_Target wins.
- Branch_Taken=1 with PCEn=0 -> ignored.
- rst_n low during WAIT -> late IMem_Ready ignored; PC=PC_RESET; fetch restarts after one HOLD cycle.
